// File: rtl/count_call_collector.sv
// count_call_collector: drives N calls into the `count` HLS component for each
// host command, collects the returns into a small first-word fall-through FIFO
// and streams them downstream with res_last marking the final result.
// Optional build macro COUNT_COLLECT_ORDER_CHECK_EN adds err_order, a sticky flag
// raised when returns within one command are not strictly increasing.
module count_call_collector #(
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CNT_W-1:0]  cmd_num_calls,
   output logic              comp_start,
   input  logic              comp_busy,
   input  logic              comp_done,
   output logic              comp_stall,
   input  logic [DATA_W-1:0] comp_returndata,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_last,
   output logic              idle
`ifdef COUNT_COLLECT_ORDER_CHECK_EN
   ,
   output logic              err_order
`endif
);

   localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    rem_issue_q, rem_issue_d;
   logic [CNT_W-1:0]    rem_ret_q, rem_ret_d;
   logic [OUT_W-1:0]    outst_q, outst_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   entry_t              mem [FIFO_DEPTH];
   entry_t              push_entry;
   entry_t              head_d;
   logic                cmd_acc, call_acc, ret_acc, push, pop;
   logic                start_d;

   // Handshake decodes; returns are only honoured while a call is in flight
   always_comb begin
      cmd_acc    = cmd_valid && cmd_ready;
      call_acc   = comp_start && !comp_busy;
      comp_stall = (fcnt_q == FCNT_W'(FIFO_DEPTH));
      ret_acc    = comp_done && !comp_stall && (outst_q != '0);
      push       = ret_acc;
      pop        = res_valid && res_ready;
      push_entry = '{last: (rem_ret_q == CNT_W'(1)), data: comp_returndata};
   end

   // Next-state logic for the FSM, call/return counters and FIFO bookkeeping
   always_comb begin
      state_d     = state_q;
      rem_issue_d = rem_issue_q;
      rem_ret_d   = rem_ret_q;
      outst_d     = outst_q;
      fcnt_d      = fcnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_acc) begin
               rem_issue_d = cmd_num_calls;
               rem_ret_d   = cmd_num_calls;
               if (cmd_num_calls != '0) begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (call_acc) begin
               rem_issue_d = rem_issue_q - CNT_W'(1);
               if (rem_issue_q == CNT_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if ((rem_ret_q == '0) && (fcnt_q == '0)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (ret_acc) begin
         rem_ret_d = rem_ret_q - CNT_W'(1);
      end

      case ({call_acc, ret_acc})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
         2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   // Head of the FIFO after this cycle; bypass the write when it lands at the head
   always_comb begin
      head_d = mem[rd_ptr_d];
      if (push && (rd_ptr_d == wr_ptr_q)) begin
         head_d = push_entry;
      end
   end

   // Issue only with a call credit and guaranteed FIFO room for its return
   always_comb begin
      start_d = (state_d == ST_ISSUE) &&
                (rem_issue_d != '0) &&
                (32'(outst_d) < MAX_OUTSTANDING) &&
                ((32'(outst_d) + 32'(fcnt_d)) < FIFO_DEPTH);
   end

   // State, counters and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         rem_issue_q <= '0;
         rem_ret_q   <= '0;
         outst_q     <= '0;
         fcnt_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         comp_start  <= 1'b0;
         cmd_ready   <= 1'b1;
         idle        <= 1'b1;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_last    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_issue_q <= rem_issue_d;
         rem_ret_q   <= rem_ret_d;
         outst_q     <= outst_d;
         fcnt_q      <= fcnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         comp_start  <= start_d;
         cmd_ready   <= (state_d == ST_IDLE);
         idle        <= (state_d == ST_IDLE) && (fcnt_d == '0);
         res_valid   <= (fcnt_d != '0);
         res_data    <= head_d.data;
         res_last    <= head_d.last;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= push_entry;
      end
   end

`ifdef COUNT_COLLECT_ORDER_CHECK_EN
   logic              have_prev_q;
   logic [DATA_W-1:0] prev_q;

   // Sticky ordering error: each return after the first of a command must exceed its predecessor
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err_order   <= 1'b0;
         have_prev_q <= 1'b0;
         prev_q      <= '0;
      end else begin
         if (cmd_acc) begin
            have_prev_q <= 1'b0;
         end
         if (ret_acc) begin
            if (have_prev_q && (comp_returndata <= prev_q)) begin
               err_order <= 1'b1;
            end
            prev_q      <= comp_returndata;
            have_prev_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_count_call_collector.sv
// Self-checking bench for count_call_collector: emulates the in-order `count`
// component, keeps a queue-based model of expected results and checks the
// result stream, credit limits and handshake rules every cycle.
module tb_count_call_collector;

   localparam int DATA_W     = 32;
   localparam int CNT_W      = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int MAX_OUT    = 2;

   logic              clock;
   logic              resetn;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CNT_W-1:0]  cmd_num_calls;
   logic              comp_start;
   logic              comp_busy;
   logic              comp_done;
   logic              comp_stall;
   logic [DATA_W-1:0] comp_returndata;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_last;
   logic              idle;
`ifdef COUNT_COLLECT_ORDER_CHECK_EN
   logic              err_order;
`endif

   count_call_collector #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clock(clock), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_calls(cmd_num_calls),
      .comp_start(comp_start), .comp_busy(comp_busy), .comp_done(comp_done),
      .comp_stall(comp_stall), .comp_returndata(comp_returndata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .idle(idle)
`ifdef COUNT_COLLECT_ORDER_CHECK_EN
      , .err_order(err_order)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks;
   int failures;

   int unsigned busy_pct, ready_pct, done_pct, step_max;
   bit          busy_force;
   logic [DATA_W-1:0] data_next;
   logic [DATA_W-1:0] force_q[$];
   logic [DATA_W-1:0] pend_q[$];
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W:0]   got_q[$];
   int  cur_n, calls_made, rets, triple_cnt;
   bit  start_wait;

   task automatic clear_model();
      pend_q.delete();
      exp_q.delete();
      force_q.delete();
      cur_n = 0; calls_made = 0; rets = 0;
      start_wait = 1'b0;
   endtask

   // One cycle: choose inputs, check observed state, predict this edge's handshakes
   task automatic tick();
      bit call, ret, pop;
      logic [DATA_W:0] e;
      comp_busy       = busy_force || ($urandom_range(99) < busy_pct);
      res_ready       = ($urandom_range(99) < ready_pct);
      comp_done       = (pend_q.size() != 0) && ($urandom_range(99) < done_pct);
      comp_returndata = (pend_q.size() != 0) ? pend_q[0] : '0;
      call = comp_start && !comp_busy;
      ret  = comp_done && !comp_stall;
      pop  = res_valid && res_ready;

      checks++;
      if (start_wait && !comp_start) begin
         failures++; $display("FAIL start_hold: comp_start=%0b required 1", comp_start);
      end
      checks++;
      if (res_valid !== (exp_q.size() != 0)) begin
         failures++; $display("FAIL res_valid: got=%0b required=%0b", res_valid, exp_q.size() != 0);
      end
      checks++;
      if (comp_stall !== (exp_q.size() == FIFO_DEPTH)) begin
         failures++; $display("FAIL comp_stall: got=%0b required=%0b", comp_stall, exp_q.size() == FIFO_DEPTH);
      end
      checks++;
      if ((pend_q.size() > MAX_OUT) || (pend_q.size() + exp_q.size() > FIFO_DEPTH)) begin
         failures++; $display("FAIL credit: outstanding=%0d buffered=%0d", pend_q.size(), exp_q.size());
      end

      if (cmd_valid && cmd_ready) begin
         cur_n = int'(cmd_num_calls); calls_made = 0; rets = 0;
      end
      if (pop) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++; $display("FAIL pop_empty: popped data=%0h with nothing expected", res_data);
         end else begin
            e = exp_q.pop_front();
            if ({res_last, res_data} !== e) begin
               failures++; $display("FAIL result: got last=%0b data=%0h required last=%0b data=%0h",
                                    res_last, res_data, e[DATA_W], e[DATA_W-1:0]);
            end
         end
         got_q.push_back({res_last, res_data});
      end
      if (call) begin
         calls_made++;
         checks++;
         if (calls_made > cur_n) begin
            failures++; $display("FAIL extra_call: calls=%0d required<=%0d", calls_made, cur_n);
         end
         if (force_q.size() != 0) pend_q.push_back(force_q.pop_front());
         else begin
            pend_q.push_back(data_next);
            data_next = data_next + DATA_W'($urandom_range(1, step_max));
         end
      end
      if (ret) begin
         rets++;
         exp_q.push_back({rets == cur_n, pend_q.pop_front()});
      end
      if (call && ret && pop) triple_cnt++;
      start_wait = comp_start && comp_busy;
      @(negedge clock);
   endtask

   task automatic start_cmd(input int n, input logic [DATA_W-1:0] first);
      data_next     = first;
      cmd_valid     = 1'b1;
      cmd_num_calls = CNT_W'(n);
      tick();
      cmd_valid     = 1'b0;
      checks++;
      if (cmd_ready !== (n == 0)) begin
         failures++; $display("FAIL cmd_ready_after_accept: got=%0b required=%0b", cmd_ready, n == 0);
      end
   endtask

   task automatic finish_cmd(input int bound);
      int k;
      k = 0;
      while (!((idle === 1'b1) && (rets == cur_n) && (exp_q.size() == 0)) && (k < bound)) begin
         tick();
         k++;
      end
      checks++;
      if (k >= bound) begin
         failures++; $display("FAIL timeout: rets=%0d required=%0d idle=%0b", rets, cur_n, idle);
      end
      checks++;
      if (calls_made != cur_n) begin
         failures++; $display("FAIL call_count: got=%0d required=%0d", calls_made, cur_n);
      end
      checks++;
      if ((cmd_ready !== 1'b1) || (comp_start !== 1'b0)) begin
         failures++; $display("FAIL end_state: cmd_ready=%0b comp_start=%0b required 1/0", cmd_ready, comp_start);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; cmd_valid = 1'b0; cmd_num_calls = '0;
      comp_busy = 1'b0; comp_done = 1'b0; comp_returndata = '0; res_ready = 1'b0;
      clear_model();
      repeat (2) @(negedge clock);
      checks++;
      if ({comp_start, comp_stall, res_valid, res_last, cmd_ready, idle} !== 6'b000011) begin
         failures++; $display("FAIL reset_ctrl: start,stall,valid,last,ready,idle=%b required 000011",
                              {comp_start, comp_stall, res_valid, res_last, cmd_ready, idle});
      end
      checks++;
      if (res_data !== '0) begin
         failures++; $display("FAIL reset_data: got=%0h required 0", res_data);
      end
`ifdef COUNT_COLLECT_ORDER_CHECK_EN
      checks++;
      if (err_order !== 1'b0) begin
         failures++; $display("FAIL reset_err: got=%0b required 0", err_order);
      end
`endif
      resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      busy_pct = 0; ready_pct = 100; done_pct = 100; step_max = 1;
      got_q.delete();
      start_cmd(3, DATA_W'(1));
      finish_cmd(60);
      checks++;
      if (got_q.size() != 3) begin
         failures++; $display("FAIL basic_count: got=%0d required 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== {i == 2, DATA_W'(i + 1)}) begin
               failures++; $display("FAIL basic_word%0d: got=%0h required last=%0b data=%0d",
                                    i, got_q[i], i == 2, i + 1);
            end
         end
      end
      checks++;
      if (idle !== 1'b1) begin
         failures++; $display("FAIL basic_idle: got=%0b required 1", idle);
      end
   endtask

   task automatic test_zero();
      start_cmd(0, DATA_W'(0));
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ((cmd_ready !== 1'b1) || (comp_start !== 1'b0) || (res_valid !== 1'b0)) begin
            failures++; $display("FAIL zero_cmd: ready=%0b start=%0b valid=%0b required 1/0/0",
                                 cmd_ready, comp_start, res_valid);
         end
         tick();
      end
   endtask

   task automatic test_busy();
      busy_force = 1'b1; busy_pct = 0;
      start_cmd(1, DATA_W'(7));
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (comp_start !== 1'b1) begin
            failures++; $display("FAIL busy_hold%0d: comp_start=%0b required 1", i, comp_start);
         end
         tick();
      end
      checks++;
      if (calls_made != 0) begin
         failures++; $display("FAIL busy_nocall: calls=%0d required 0", calls_made);
      end
      busy_force = 1'b0;
      tick();
      checks++;
      if (calls_made != 1) begin
         failures++; $display("FAIL busy_onecall: calls=%0d required 1", calls_made);
      end
      finish_cmd(60);
   endtask

   task automatic test_backpressure();
      busy_pct = 0; ready_pct = 0; done_pct = 100; step_max = 3;
      got_q.delete();
      start_cmd(8, DATA_W'($urandom_range(0, 100)));
      repeat (30) tick();
      checks++;
      if ((calls_made != FIFO_DEPTH) || (rets != FIFO_DEPTH)) begin
         failures++; $display("FAIL bp_stop: calls=%0d rets=%0d required %0d", calls_made, rets, FIFO_DEPTH);
      end
      checks++;
      if (comp_stall !== 1'b1) begin
         failures++; $display("FAIL bp_full: comp_stall=%0b required 1", comp_stall);
      end
      ready_pct = 100;
      finish_cmd(200);
      checks++;
      if ((got_q.size() != 8) || (got_q[got_q.size() - 1][DATA_W] !== 1'b1)) begin
         failures++; $display("FAIL bp_drain: words=%0d required 8 with final last=1", got_q.size());
      end
   endtask

   task automatic test_back_to_back();
      busy_pct = 0; ready_pct = 100; done_pct = 100; step_max = 2;
      triple_cnt = 0;
      start_cmd(10, DATA_W'(3));
      finish_cmd(200);
      checks++;
      if (triple_cnt == 0) begin
         failures++; $display("FAIL same_cycle: simultaneous call/return/pop count=%0d required >0", triple_cnt);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 8; c++) begin
         busy_pct  = $urandom_range(0, 60);
         ready_pct = $urandom_range(20, 100);
         done_pct  = $urandom_range(30, 100);
         step_max  = $urandom_range(1, 4);
         start_cmd(int'($urandom_range(1, 12)), DATA_W'($urandom_range(0, 3)));
         finish_cmd(3000);
         repeat ($urandom_range(0, 3)) tick();
      end
`ifdef COUNT_COLLECT_ORDER_CHECK_EN
      checks++;
      if (err_order !== 1'b0) begin
         failures++; $display("FAIL order_clean: err_order=%0b required 0", err_order);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int k;
      busy_pct = 0; ready_pct = 0; done_pct = 100; step_max = 1;
      start_cmd(5, DATA_W'(20));
      k = 0;
      while ((rets < 2) && (k < 100)) begin
         tick();
         k++;
      end
      checks++;
      if (rets != 2) begin
         failures++; $display("FAIL mid_progress: rets=%0d required 2", rets);
      end
      resetn = 1'b0; comp_done = 1'b0;
      #1;
      checks++;
      if ((comp_start !== 1'b0) || (res_valid !== 1'b0) || (cmd_ready !== 1'b1)) begin
         failures++; $display("FAIL mid_reset: start=%0b valid=%0b ready=%0b required 0/0/1",
                              comp_start, res_valid, cmd_ready);
      end
      clear_model();
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      ready_pct = 100;
      force_q.push_back(DATA_W'(5));
      force_q.push_back(DATA_W'(4));
      start_cmd(2, DATA_W'(0));
      finish_cmd(100);
`ifdef COUNT_COLLECT_ORDER_CHECK_EN
      checks++;
      if (err_order !== 1'b1) begin
         failures++; $display("FAIL order_set: err_order=%0b required 1", err_order);
      end
      start_cmd(3, DATA_W'(1));
      finish_cmd(100);
      checks++;
      if (err_order !== 1'b1) begin
         failures++; $display("FAIL order_sticky: err_order=%0b required 1", err_order);
      end
`endif
   endtask

   initial begin
      checks = 0; failures = 0; triple_cnt = 0;
      busy_pct = 0; ready_pct = 100; done_pct = 100; step_max = 1; busy_force = 1'b0;
      data_next = '0;
      test_reset();
      test_basic();
      test_zero();
      test_busy();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
